// File: rtl/xcel_data_mem.sv
// Word-addressed data memory with val/rdy request/response channels, fixed read latency,
// in-order response buffer and a post-reset init FSM that fills every word.
module xcel_data_mem #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1,
  parameter int INIT_MODE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memreq_val,
  output logic              memreq_rdy,
  input  logic              memreq_type,
  input  logic [ADDR_W-1:0] memreq_addr,
  input  logic [DATA_W-1:0] memreq_data,
  output logic              memresp_val,
  input  logic              memresp_rdy,
  output logic              memresp_type,
  output logic [DATA_W-1:0] memresp_data,
  output logic              init_busy,
  output logic              err_misaligned
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int FD    = LATENCY + 1;
  localparam int CW    = $clog2(LATENCY + 2);
  localparam int PW    = $clog2(FD);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [LATENCY-1:0]      pvld_q, pvld_d;
  logic [LATENCY-1:0]      ptype_q, ptype_d;
  logic [DATA_W-1:0]       pdata_q [LATENCY];
  logic [DATA_W-1:0]       pdata_d [LATENCY];
  logic [DATA_W-1:0]       fdata_q [FD];
  logic [FD-1:0]           ftype_q;
  logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]           fcnt_q, fcnt_d;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic                    req_fire, resp_fire, last_vld, fifo_empty, push, pop;
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   word_idx, mem_waddr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    unused_addr;

  assign unused_addr = ^memreq_addr;
  assign word_idx    = memreq_addr[DEPTH_LOG2+1:2];

  // Ready comes only from registered state, so it never loops through memreq_val.
  assign memreq_rdy     = (state_q == ST_RUN) && (cnt_q < CW'(FD));
  assign init_busy      = (state_q == ST_INIT);
  assign err_misaligned = err_q;
  assign req_fire       = memreq_val && memreq_rdy;

  // The last pipe stage bypasses the buffer when it is empty, keeping latency at LATENCY.
  assign last_vld     = pvld_q[LATENCY-1];
  assign fifo_empty   = (fcnt_q == '0);
  assign memresp_val  = !fifo_empty || last_vld;
  assign memresp_type = fifo_empty ? (last_vld && ptype_q[LATENCY-1]) : ftype_q[rp_q];
  assign memresp_data = fifo_empty ? (last_vld ? pdata_q[LATENCY-1] : '0) : fdata_q[rp_q];
  assign resp_fire    = memresp_val && memresp_rdy;
  assign push         = last_vld && !(fifo_empty && memresp_rdy);
  assign pop          = !fifo_empty && memresp_rdy;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = word_idx;
    mem_wdata = memreq_data;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = idx_q;
      mem_wdata = (INIT_MODE == 1) ? DATA_W'(idx_q) : '0;
      idx_d     = idx_q + DEPTH_LOG2'(1);
      if (idx_q == DEPTH_LOG2'(DEPTH - 1)) state_d = ST_RUN;
    end else begin
      mem_we = req_fire && memreq_type;
      if (req_fire && (memreq_addr[1:0] != 2'b00)) err_d = 1'b1;
    end
  end

  always_comb begin
    pvld_d     = '0;
    ptype_d    = '0;
    pvld_d[0]  = req_fire;
    ptype_d[0] = memreq_type;
    pdata_d[0] = (req_fire && !memreq_type) ? mem[word_idx] : '0;
    for (int i = 1; i < LATENCY; i++) begin
      pvld_d[i]  = pvld_q[i-1];
      ptype_d[i] = ptype_q[i-1];
      pdata_d[i] = pdata_q[i-1];
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    fcnt_d = fcnt_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    case ({req_fire, resp_fire})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push) wp_d = (wp_q == PW'(FD - 1)) ? '0 : wp_q + PW'(1);
    if (pop)  rp_d = (rp_q == PW'(FD - 1)) ? '0 : rp_q + PW'(1);
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CW'(1);
      2'b01:   fcnt_d = fcnt_q - CW'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      pvld_q  <= '0;
      ptype_q <= '0;
      for (int i = 0; i < LATENCY; i++) pdata_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      pvld_q  <= pvld_d;
      ptype_q <= ptype_d;
      for (int i = 0; i < LATENCY; i++) pdata_q[i] <= pdata_d[i];
    end
  end

  // Storage arrays carry no reset; their contents are only observed through valid state.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (push) begin
      fdata_q[wp_q] <= pdata_q[LATENCY-1];
      ftype_q[wp_q] <= ptype_q[LATENCY-1];
    end
  end
endmodule
